riscv_id_ex_hazard_stage: RTL and testbench

//  ID->EX boundary of the 5-stage RV32I pipeline. Consumes decoded ID-stage fields and register data.

---
 rtl/riscv_id_ex_hazard_stage.sv | 154 +++++++++++++++
 tb/tb_riscv_id_ex_hazard_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_id_ex_hazard_stage.sv
// ID/EX pipeline boundary: main-control decode, load-use hazard detection, bubble insertion
// on stall or branch flush, and saturating event counters for both bubble causes.
module riscv_id_ex_hazard_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic [XLEN-1:0]  PC_ID,
  input  logic [XLEN-1:0]  IMM_ID,
  input  logic [XLEN-1:0]  REG_DATA1_ID,
  input  logic [XLEN-1:0]  REG_DATA2_ID,
  input  logic [2:0]       FUNCT3_ID,
  input  logic [6:0]       FUNCT7_ID,
  input  logic [6:0]       OPCODE_ID,
  input  logic [4:0]       RD_ID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic [XLEN-1:0]  PC_EX,
  output logic [XLEN-1:0]  IMM_EX,
  output logic [XLEN-1:0]  REG_DATA1_EX,
  output logic [XLEN-1:0]  REG_DATA2_EX,
  output logic [2:0]       FUNCT3_EX,
  output logic [6:0]       FUNCT7_EX,
  output logic [4:0]       RD_EX,
  output logic [4:0]       RS1_EX,
  output logic [4:0]       RS2_EX,
  output logic             RegWrite_EX,
  output logic             MemtoReg_EX,
  output logic             MemRead_EX,
  output logic             MemWrite_EX,
  output logic             ALUSrc_EX,
  output logic             Branch_EX,
  output logic [1:0]       ALUOp_EX,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluCmp   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  ctrl_t            ctrl_id;
  ctrl_t            ctrl_q;
  logic             hazard;
  logic             bubble;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_comb begin
    ctrl_id = '0;
    case (OPCODE_ID)
      OpRType: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.alu_op    = AluFunct;
      end
      OpIAlu: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.alu_op    = AluFunct;
      end
      OpLoad: begin
        ctrl_id.reg_write  = 1'b1;
        ctrl_id.mem_to_reg = 1'b1;
        ctrl_id.mem_read   = 1'b1;
        ctrl_id.alu_src    = 1'b1;
        ctrl_id.alu_op     = AluAdd;
      end
      OpStore: begin
        ctrl_id.mem_write = 1'b1;
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.alu_op    = AluAdd;
      end
      OpBranch: begin
        ctrl_id.branch = 1'b1;
        ctrl_id.alu_op = AluCmp;
      end
      default: ctrl_id = '0;
    endcase
  end

  // rs2 is compared for every format; a spurious stall only costs a cycle.
  assign hazard = ctrl_q.mem_read & (RD_EX != 5'd0) &
                  ((RD_EX == RS1_ID) | (RD_EX == RS2_ID)) & ~PCSrc;
  assign bubble = PCSrc | hazard;

  assign PC_write    = ~hazard;
  assign IF_ID_write = ~hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_EX        <= '0;
      IMM_EX       <= '0;
      REG_DATA1_EX <= '0;
      REG_DATA2_EX <= '0;
      FUNCT3_EX    <= '0;
      FUNCT7_EX    <= '0;
      RD_EX        <= '0;
      RS1_EX       <= '0;
      RS2_EX       <= '0;
      ctrl_q       <= '0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      // Data fields load unconditionally; a bubble is made harmless by zeroed control.
      PC_EX        <= PC_ID;
      IMM_EX       <= IMM_ID;
      REG_DATA1_EX <= REG_DATA1_ID;
      REG_DATA2_EX <= REG_DATA2_ID;
      FUNCT3_EX    <= FUNCT3_ID;
      FUNCT7_EX    <= FUNCT7_ID;
      RD_EX        <= RD_ID;
      RS1_EX       <= RS1_ID;
      RS2_EX       <= RS2_ID;
      ctrl_q       <= bubble ? ctrl_t'('0) : ctrl_id;
      if (PCSrc && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + CNT_W'(1);
      end
      if (hazard && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign RegWrite_EX = ctrl_q.reg_write;
  assign MemtoReg_EX = ctrl_q.mem_to_reg;
  assign MemRead_EX  = ctrl_q.mem_read;
  assign MemWrite_EX = ctrl_q.mem_write;
  assign ALUSrc_EX   = ctrl_q.alu_src;
  assign Branch_EX   = ctrl_q.branch;
  assign ALUOp_EX    = ctrl_q.alu_op;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_riscv_id_ex_hazard_stage.sv
// Bench for riscv_id_ex_hazard_stage: directed vector table, a counter-saturation sequence on a
// CNT_W=2 instance, then randomized traffic against a table-lookup reference model.
module tb_riscv_id_ex_hazard_stage;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63;
  localparam logic [7:0] C_R  = 8'b1000_0010;
  localparam logic [7:0] C_I  = 8'b1000_1010;
  localparam logic [7:0] C_LD = 8'b1110_1000;
  localparam logic [7:0] C_ST = 8'b0001_1000;
  localparam logic [7:0] C_BR = 8'b0000_0101;

  logic clk = 1'b0;
  logic reset, PCSrc;
  logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
  logic [2:0] FUNCT3_ID;
  logic [6:0] FUNCT7_ID, OPCODE_ID;
  logic [4:0] RD_ID, RS1_ID, RS2_ID;

  logic pcw, ifw, rw, m2r, mr, mw, asrc, br;
  logic [1:0] aop;
  logic [31:0] pc_ex, imm_ex, d1_ex, d2_ex;
  logic [2:0] f3_ex;
  logic [6:0] f7_ex;
  logic [4:0] rd_ex, rs1_ex, rs2_ex;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_pcw, s_ifw, s_rw, s_m2r, s_mr, s_mw, s_asrc, s_br;
  logic [1:0] s_aop;
  logic [31:0] s_pc_ex, s_imm_ex, s_d1_ex, s_d2_ex;
  logic [2:0] s_f3_ex;
  logic [6:0] s_f7_ex;
  logic [4:0] s_rd_ex, s_rs1_ex, s_rs2_ex;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  wire [7:0] ctrl_ex   = {rw, m2r, mr, mw, asrc, br, aop};
  wire [7:0] s_ctrl_ex = {s_rw, s_m2r, s_mr, s_mw, s_asrc, s_br, s_aop};

  riscv_id_ex_hazard_stage dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
    .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID), .FUNCT3_ID(FUNCT3_ID),
    .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID), .RD_ID(RD_ID), .RS1_ID(RS1_ID),
    .RS2_ID(RS2_ID), .PC_write(pcw), .IF_ID_write(ifw), .PC_EX(pc_ex), .IMM_EX(imm_ex),
    .REG_DATA1_EX(d1_ex), .REG_DATA2_EX(d2_ex), .FUNCT3_EX(f3_ex), .FUNCT7_EX(f7_ex),
    .RD_EX(rd_ex), .RS1_EX(rs1_ex), .RS2_EX(rs2_ex), .RegWrite_EX(rw), .MemtoReg_EX(m2r),
    .MemRead_EX(mr), .MemWrite_EX(mw), .ALUSrc_EX(asrc), .Branch_EX(br), .ALUOp_EX(aop),
    .stall_count(stall_cnt), .flush_count(flush_cnt)
  );

  riscv_id_ex_hazard_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
    .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID), .FUNCT3_ID(FUNCT3_ID),
    .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID), .RD_ID(RD_ID), .RS1_ID(RS1_ID),
    .RS2_ID(RS2_ID), .PC_write(s_pcw), .IF_ID_write(s_ifw), .PC_EX(s_pc_ex),
    .IMM_EX(s_imm_ex), .REG_DATA1_EX(s_d1_ex), .REG_DATA2_EX(s_d2_ex), .FUNCT3_EX(s_f3_ex),
    .FUNCT7_EX(s_f7_ex), .RD_EX(s_rd_ex), .RS1_EX(s_rs1_ex), .RS2_EX(s_rs2_ex),
    .RegWrite_EX(s_rw), .MemtoReg_EX(s_m2r), .MemRead_EX(s_mr), .MemWrite_EX(s_mw),
    .ALUSrc_EX(s_asrc), .Branch_EX(s_br), .ALUOp_EX(s_aop), .stall_count(s_stall_cnt),
    .flush_count(s_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        pcsrc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc;
    logic        chk_pcw;
    logic        pcw;
    logic [7:0]  ctrl;
    logic        chk_data;
    logic [4:0]  rd_ex;
    logic [31:0] pc_ex;
    int          stall;
    int          flush;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic pcsrc, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] pc, input logic chk_pcw, input logic exp_pcw,
                     input logic [7:0] ctrl, input logic chk_data, input logic [4:0] erd,
                     input logic [31:0] epc, input int stall, input int flush);
    vec_t v;
    v = '{rst, pcsrc, op, rd, rs1, rs2, pc, chk_pcw, exp_pcw, ctrl, chk_data, erd, epc,
          stall, flush};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic pcsrc, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] pc);
    @(negedge clk);
    reset = rst; PCSrc = pcsrc; OPCODE_ID = op; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
    PC_ID = pc; IMM_ID = pc ^ 32'h5a5a_0000; REG_DATA1_ID = pc + 32'd1;
    REG_DATA2_ID = pc + 32'd2; FUNCT3_ID = pc[4:2]; FUNCT7_ID = 7'h20;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: the EX-side contents and raw event counts since reset.
  logic [7:0]  ctrl_tab [128];
  logic [7:0]  m_ctrl;
  logic [31:0] m_pc, m_imm, m_d1, m_d2;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic        m_data_ok, m_haz;
  int          raw_stall, raw_flush;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  initial begin
    reset = 1'b1; PCSrc = 1'b0; OPCODE_ID = '0; RD_ID = '0; RS1_ID = '0; RS2_ID = '0;
    PC_ID = '0; IMM_ID = '0; REG_DATA1_ID = '0; REG_DATA2_ID = '0; FUNCT3_ID = '0;
    FUNCT7_ID = '0;

    //  rst pcs op     rd rs1 rs2 pc         chk pcw ctrl  dat rd  pc_ex      st fl
    add(1, 0, OP_R,   5, 1, 2, 32'h00,    0, 1, 8'h0, 1, 0, 32'h00,    0, 0);
    add(1, 0, 7'h0,   0, 0, 0, 32'h00,    1, 1, 8'h0, 1, 0, 32'h00,    0, 0);
    add(0, 0, OP_R,   5, 1, 2, 32'h10,    1, 1, C_R,  1, 5, 32'h10,    0, 0);
    add(0, 0, OP_LD,  3, 2, 0, 32'h14,    1, 1, C_LD, 1, 3, 32'h14,    0, 0);
    add(0, 0, OP_R,   4, 3, 1, 32'h18,    1, 0, 8'h0, 0, 0, 32'h00,    1, 0);
    add(0, 0, OP_R,   4, 3, 1, 32'h18,    1, 1, C_R,  1, 4, 32'h18,    1, 0);
    add(0, 0, OP_LD,  7, 1, 0, 32'h1c,    1, 1, C_LD, 1, 7, 32'h1c,    1, 0);
    add(0, 1, OP_R,   8, 7, 7, 32'h20,    1, 1, 8'h0, 0, 0, 32'h00,    1, 1);
    add(0, 0, OP_LD,  0, 1, 0, 32'h24,    1, 1, C_LD, 1, 0, 32'h24,    1, 1);
    add(0, 0, OP_R,   4, 0, 0, 32'h28,    1, 1, C_R,  1, 4, 32'h28,    1, 1);
    add(0, 0, 7'h7f,  9, 0, 0, 32'h2c,    1, 1, 8'h0, 1, 9, 32'h2c,    1, 1);
    add(0, 0, OP_ST,  1, 2, 9, 32'h30,    1, 1, C_ST, 1, 1, 32'h30,    1, 1);
    add(0, 0, OP_BR,  2, 1, 1, 32'h34,    1, 1, C_BR, 1, 2, 32'h34,    1, 1);
    add(0, 0, OP_I,   6, 1, 0, 32'h38,    1, 1, C_I,  1, 6, 32'h38,    1, 1);
    add(0, 0, OP_LD,  9, 6, 0, 32'h3c,    1, 1, C_LD, 1, 9, 32'h3c,    1, 1);
    add(1, 0, OP_ST,  1, 2, 9, 32'h40,    1, 0, 8'h0, 1, 0, 32'h00,    0, 0);
    add(0, 0, OP_ST,  1, 2, 9, 32'h40,    1, 1, C_ST, 1, 1, 32'h40,    0, 0);
    add(0, 0, OP_LD,  5, 0, 0, 32'h44,    1, 1, C_LD, 1, 5, 32'h44,    0, 0);
    add(0, 0, OP_R,   6, 0, 5, 32'h48,    1, 0, 8'h0, 0, 0, 32'h00,    1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pcsrc, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].pc);
      #1;
      if (vecs[i].chk_pcw) begin
        check($sformatf("vec%0d PC_write", i), 64'(pcw), 64'(vecs[i].pcw));
        check($sformatf("vec%0d IF_ID_write", i), 64'(ifw), 64'(vecs[i].pcw));
      end
      tick();
      check($sformatf("vec%0d control", i), 64'(ctrl_ex), 64'(vecs[i].ctrl));
      check($sformatf("vec%0d stall_count", i), 64'(stall_cnt), 64'(vecs[i].stall));
      check($sformatf("vec%0d flush_count", i), 64'(flush_cnt), 64'(vecs[i].flush));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d RD_EX", i), 64'(rd_ex), 64'(vecs[i].rd_ex));
        check($sformatf("vec%0d PC_EX", i), 64'(pc_ex), 64'(vecs[i].pc_ex));
      end
    end

    // Five load-use pairs: the 2-bit counter must stop at 3 while the wide one reaches 5.
    drive(1, 0, 7'h0, 0, 0, 0, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, OP_LD, 3, 0, 0, 32'h100);
      tick();
      drive(0, 0, OP_R, 4, 3, 0, 32'h104);
      #1;
      check($sformatf("sat%0d PC_write", k), 64'(s_pcw), 64'(0));
      tick();
      check($sformatf("sat%0d bubble", k), 64'(s_ctrl_ex), 64'(0));
      check($sformatf("sat%0d stall_count", k), 64'(s_stall_cnt), 64'(sat(k + 1, 3)));
      drive(0, 0, OP_R, 4, 3, 0, 32'h104);
      tick();
    end
    check("sat wide stall_count", 64'(stall_cnt), 64'(5));
    check("sat narrow stall_count", 64'(s_stall_cnt), 64'(3));

    for (int i = 0; i < 128; i++) ctrl_tab[i] = 8'h0;
    ctrl_tab[OP_R] = C_R; ctrl_tab[OP_I] = C_I; ctrl_tab[OP_LD] = C_LD;
    ctrl_tab[OP_ST] = C_ST; ctrl_tab[OP_BR] = C_BR;

    drive(1, 0, 7'h0, 0, 0, 0, 32'h0);
    tick();
    m_ctrl = '0; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0; m_f3 = '0; m_f7 = '0;
    m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_data_ok = 1'b1; raw_stall = 0; raw_flush = 0;

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 63) == 0);
      PCSrc = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 6))
        0: OPCODE_ID = OP_R;
        1: OPCODE_ID = OP_I;
        2, 3: OPCODE_ID = OP_LD;
        4: OPCODE_ID = OP_ST;
        5: OPCODE_ID = OP_BR;
        default: OPCODE_ID = 7'($urandom);
      endcase
      RD_ID = 5'($urandom_range(0, 3)); RS1_ID = 5'($urandom_range(0, 3));
      RS2_ID = 5'($urandom_range(0, 3));
      PC_ID = $urandom; IMM_ID = $urandom; REG_DATA1_ID = $urandom; REG_DATA2_ID = $urandom;
      FUNCT3_ID = 3'($urandom); FUNCT7_ID = 7'($urandom);
      #1;
      m_haz = m_ctrl[5] && (m_rd != 0) && ((m_rd == RS1_ID) || (m_rd == RS2_ID)) && !PCSrc;
      check("rand PC_write", 64'(pcw), 64'(!m_haz));
      check("rand IF_ID_write", 64'(ifw), 64'(!m_haz));
      check("rand sat PC_write", 64'(s_pcw), 64'(!m_haz));
      if (reset) begin
        m_ctrl = '0; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0; m_f3 = '0; m_f7 = '0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_data_ok = 1'b1; raw_stall = 0; raw_flush = 0;
      end else begin
        m_ctrl = (PCSrc || m_haz) ? 8'h0 : ctrl_tab[OPCODE_ID];
        m_pc = PC_ID; m_imm = IMM_ID; m_d1 = REG_DATA1_ID; m_d2 = REG_DATA2_ID;
        m_f3 = FUNCT3_ID; m_f7 = FUNCT7_ID; m_rd = RD_ID; m_rs1 = RS1_ID; m_rs2 = RS2_ID;
        m_data_ok = !(PCSrc || m_haz);
        if (PCSrc) raw_flush++;
        else if (m_haz) raw_stall++;
      end
      tick();
      check("rand control", 64'(ctrl_ex), 64'(m_ctrl));
      check("rand sat control", 64'(s_ctrl_ex), 64'(m_ctrl));
      check("rand stall_count", 64'(stall_cnt), 64'(sat(raw_stall, 65535)));
      check("rand flush_count", 64'(flush_cnt), 64'(sat(raw_flush, 65535)));
      check("rand sat stall_count", 64'(s_stall_cnt), 64'(sat(raw_stall, 3)));
      check("rand sat flush_count", 64'(s_flush_cnt), 64'(sat(raw_flush, 3)));
      if (m_data_ok) begin
        check("rand PC_EX", 64'(pc_ex), 64'(m_pc));
        check("rand IMM_EX", 64'(imm_ex), 64'(m_imm));
        check("rand REG_DATA1_EX", 64'(d1_ex), 64'(m_d1));
        check("rand REG_DATA2_EX", 64'(d2_ex), 64'(m_d2));
        check("rand FUNCT3_EX", 64'(f3_ex), 64'(m_f3));
        check("rand FUNCT7_EX", 64'(f7_ex), 64'(m_f7));
        check("rand RD_EX", 64'(rd_ex), 64'(m_rd));
        check("rand RS1_EX", 64'(rs1_ex), 64'(m_rs1));
        check("rand RS2_EX", 64'(rs2_ex), 64'(m_rs2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
